// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter merging NREQ byte producers onto one UART TX stream.
// Latency: request in IDLE -> ready next cycle -> registered beat on o_valid one cycle later.
// Backpressure: o_ready[grant] = !o_valid | i_ready, so a stalled output stage stalls the owner.
module uart_tx_arbiter #(
    parameter int NREQ   = 4,
    parameter int DLEN   = 8,
    parameter int MAXLEN = 64,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW    = $clog2(MAXLEN + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      i_valid,
    output logic [NREQ-1:0]      o_ready,
    input  logic [NREQ*DLEN-1:0] i_data,
    input  logic [NREQ-1:0]      i_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DLEN-1:0]      o_data,
    output logic                 o_last,
    output logic [IDW-1:0]       o_id,
    output logic                 o_busy,
    output logic                 o_trunc
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  ptr;
    logic [CW-1:0]   cnt;
    logic [IDW-1:0]  winner;
    logic            any_req;
    logic            sel_valid;
    logic            sel_last;
    logic [DLEN-1:0] sel_data;
    logic            stage_free;
    logic            accept;
    logic            at_limit;
    logic            release_pkt;

    // Round-robin search: first requester after ptr, wrapping; scanning from the
    // far end downwards lets the nearest candidate overwrite the earlier ones.
    always_comb begin
        logic [IDW-1:0] cand;
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int j = NREQ; j >= 1; j--) begin
            cand = IDW'((int'(ptr) + j) % NREQ);
            if (i_valid[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    // Select the granted requester's beat.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == IDW'(k)) begin
                sel_valid = i_valid[k];
                sel_last  = i_last[k];
                sel_data  = i_data[k*DLEN +: DLEN];
            end
        end
    end

    assign stage_free  = !o_valid || i_ready;
    assign accept      = (state == LOCKED) && sel_valid && stage_free;
    assign at_limit    = (cnt == CW'(MAXLEN - 1));
    assign release_pkt = accept && (sel_last || at_limit);
    assign o_busy      = (state == LOCKED);

    // Only the owner of the lock ever sees ready; nobody does while arbitrating.
    always_comb begin
        o_ready = '0;
        if (state == LOCKED) begin
            for (int k = 0; k < NREQ; k++) begin
                if (grant == IDW'(k)) begin
                    o_ready[k] = stage_free;
                end
            end
        end
    end

    // Next-state logic: lock on any request, unlock when the packet ends or hits the beat limit.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = LOCKED;
            LOCKED:  if (release_pkt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant, round-robin pointer and per-packet beat counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            grant <= '0;
            ptr   <= IDW'(NREQ - 1);
            cnt   <= '0;
        end else if (state == IDLE && any_req) begin
            grant <= winner;
            cnt   <= '0;
        end else if (accept) begin
            cnt <= cnt + CW'(1);
            if (release_pkt) begin
                ptr <= grant;
            end
        end
    end

    // Registered output stage; a limit cut forces o_last and flags o_trunc.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_id    <= '0;
            o_trunc <= 1'b0;
        end else begin
            o_trunc <= accept && at_limit && !sel_last;
            if (accept) begin
                o_valid <= 1'b1;
                o_data  <= sel_data;
                o_last  <= sel_last || at_limit;
                o_id    <= grant;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level round-robin reference model feeding a scoreboard.
// Expected beat order is computed when a round starts; a negedge monitor pops and compares.
// Random downstream backpressure and mid-packet valid gaps; directed latency, limit and reset cases.
module tb_uart_tx_arbiter;

    localparam int NREQ   = 4;
    localparam int DLEN   = 8;
    localparam int MAXLEN = 4;
    localparam int MAXB   = 64;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      i_valid;
    logic [NREQ-1:0]      o_ready;
    logic [NREQ*DLEN-1:0] i_data;
    logic [NREQ-1:0]      i_last;
    logic                 o_valid;
    logic                 i_ready;
    logic [DLEN-1:0]      o_data;
    logic                 o_last;
    logic [1:0]           o_id;
    logic                 o_busy;
    logic                 o_trunc;

    uart_tx_arbiter #(.NREQ(NREQ), .DLEN(DLEN), .MAXLEN(MAXLEN)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_id    (o_id),
        .o_busy  (o_busy),
        .o_trunc (o_trunc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] d;
        logic       l;
        logic       t;
    } exp_t;

    exp_t      expq[$];
    exp_t      mon_e;
    int        total = 0;
    int        bad = 0;
    int        exp_trunc = 0;
    int        seen_trunc = 0;
    bit        mon_en = 1'b0;
    bit        gaps = 1'b0;
    bit        force_ready = 1'b0;
    int        mptr;

    logic [7:0]      bd [NREQ][MAXB];
    logic            bl [NREQ][MAXB];
    logic            bs [NREQ][MAXB];
    int              blen [NREQ];
    int              pos [NREQ];
    logic [NREQ-1:0] fire;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: protocol properties every cycle, beat contents on each handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ready_onehot", 32'($countones(o_ready) <= 1), 32'd1);
            if (o_valid && !i_ready) chk("ready_while_stalled", 32'(o_ready), 32'd0);
            if (o_trunc) begin
                seen_trunc++;
                chk("trunc_on_last_beat", {30'd0, o_valid, o_last}, 32'd3);
                chk("trunc_expected", (expq.size() > 0) ? 32'(expq[0].t) : 32'd0, 32'd1);
            end
            if (o_valid && i_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: actual id=%0d data=%0h required none", o_id, o_data);
                end else begin
                    mon_e = expq.pop_front();
                    chk("beat_id", 32'(o_id), 32'(mon_e.id));
                    chk("beat_data", 32'(o_data), 32'(mon_e.d));
                    chk("beat_last", 32'(o_last), 32'(mon_e.l));
                end
            end
        end
    end

    task automatic clear_streams();
        for (int k = 0; k < NREQ; k++) begin
            blen[k] = 0;
            pos[k]  = 0;
        end
        fire = '0;
    endtask

    task automatic add_beat(input int k, input logic [7:0] d, input logic l);
        bd[k][blen[k]] = d;
        bl[k][blen[k]] = l;
        blen[k]++;
    endtask

    // Called just after a rising edge: advance accepted beats, present the next ones.
    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            if (fire[k]) pos[k]++;
            if (pos[k] < blen[k]) begin
                i_data[k*DLEN +: DLEN] = bd[k][pos[k]];
                i_last[k]  = bl[k][pos[k]];
                i_valid[k] = bs[k][pos[k]] || !gaps || ($urandom_range(0, 3) != 0);
            end else begin
                i_data[k*DLEN +: DLEN] = '0;
                i_last[k]  = 1'b0;
                i_valid[k] = 1'b0;
            end
        end
        fire    = '0;
        i_ready = force_ready || ($urandom_range(0, 3) != 0);
    endtask

    task automatic tick_neg();
        @(negedge clk);
        fire = i_valid & o_ready;
    endtask

    task automatic tick_pos();
        @(posedge clk);
        #1;
        drive();
    endtask

    // Reference model: whole packets served round-robin after the last served index;
    // a packet ends on its last flag or after MAXLEN beats (then it is truncated and
    // the rest of that stream competes as a fresh packet).
    task automatic start_round();
        int   idx [NREQ];
        int   k;
        int   c;
        int   cnt;
        bit   done;
        exp_t e;
        for (int j = 0; j < NREQ; j++) idx[j] = 0;
        exp_trunc  = 0;
        seen_trunc = 0;
        for (int guard = 0; guard < 1000; guard++) begin
            k = -1;
            for (int j = 1; j <= NREQ; j++) begin
                c = (mptr + j) % NREQ;
                if (k < 0 && idx[c] < blen[c]) k = c;
            end
            if (k < 0) break;
            cnt  = 0;
            done = 1'b0;
            while (!done && idx[k] < blen[k]) begin
                bs[k][idx[k]] = (cnt == 0);
                cnt++;
                done = bl[k][idx[k]] || (cnt == MAXLEN);
                e.id = 2'(k);
                e.d  = bd[k][idx[k]];
                e.l  = done;
                e.t  = done && !bl[k][idx[k]];
                if (e.t) exp_trunc++;
                expq.push_back(e);
                idx[k]++;
            end
            mptr = k;
        end
        drive();
    endtask

    task automatic run_round(input string name, output int ncyc);
        bit fin;
        fin  = 1'b0;
        ncyc = 0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            tick_neg();
            tick_pos();
            ncyc++;
            fin = (expq.size() == 0);
            for (int k = 0; k < NREQ; k++) if (pos[k] < blen[k]) fin = 1'b0;
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: actual pending=%0d required 0", name, expq.size());
            expq.delete();
        end
        chk({name, "_trunc_count"}, 32'(seen_trunc), 32'(exp_trunc));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_o_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_o_last"},  32'(o_last),  32'd0);
        chk({tag, "_o_id"},    32'(o_id),    32'd0);
        chk({tag, "_o_data"},  32'(o_data),  32'd0);
        chk({tag, "_o_trunc"}, 32'(o_trunc), 32'd0);
        chk({tag, "_o_busy"},  32'(o_busy),  32'd0);
        chk({tag, "_o_ready"}, 32'(o_ready), 32'd0);
    endtask

    initial begin
        int n;
        int np;
        int len;
        bit any;

        rstn    = 1'b0;
        i_valid = '0;
        i_data  = '0;
        i_last  = '0;
        i_ready = 1'b0;
        mptr    = NREQ - 1;
        clear_streams();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Beat limit: requester 0 sends 6 beats, requester 3 waits with a short packet.
        force_ready = 1'b1;
        gaps        = 1'b0;
        clear_streams();
        for (int b = 0; b < 6; b++) add_beat(0, 8'hA0 + 8'(b), b == 5);
        add_beat(3, 8'h30, 1'b0);
        add_beat(3, 8'h31, 1'b1);
        start_round();
        run_round("limit", n);
        chk("limit_trunc_seen", 32'(seen_trunc), 32'd1);

        // Single requester latency and timing of a 3-byte packet.
        clear_streams();
        add_beat(2, 8'h41, 1'b0);
        add_beat(2, 8'h42, 1'b0);
        add_beat(2, 8'h43, 1'b1);
        start_round();
        tick_neg();
        chk("lat_c0_busy", 32'(o_busy), 32'd0);
        chk("lat_c0_ready", 32'(o_ready), 32'd0);
        tick_pos();
        tick_neg();
        chk("lat_c1_busy", 32'(o_busy), 32'd1);
        chk("lat_c1_ready", 32'(o_ready), 32'b0100);
        chk("lat_c1_valid", 32'(o_valid), 32'd0);
        tick_pos();
        tick_neg();
        chk("lat_c2_beat", {o_valid, o_last, 6'd0, 6'd0, o_id, 8'd0, o_data}, {1'b1, 1'b0, 12'd0, 2'd2, 8'd0, 8'h41});
        tick_pos();
        tick_neg();
        chk("lat_c3_data", 32'(o_data), 32'h42);
        chk("lat_c3_busy", 32'(o_busy), 32'd1);
        tick_pos();
        tick_neg();
        chk("lat_c4_beat", {o_valid, o_last, 22'd0, o_data}, {1'b1, 1'b1, 22'd0, 8'h43});
        chk("lat_c4_busy", 32'(o_busy), 32'd0);
        tick_pos();
        run_round("latency", n);

        // All four requesters, three 2-beat packets each, no stalls: one idle cycle per packet.
        clear_streams();
        for (int k = 0; k < NREQ; k++)
            for (int p = 0; p < 3; p++) begin
                add_beat(k, 8'((k << 4) | (p << 1)), 1'b0);
                add_beat(k, 8'((k << 4) | (p << 1) | 1), 1'b1);
            end
        start_round();
        run_round("fair", n);
        chk("fair_cycles", 32'(n), 32'd37);

        // Random rounds with backpressure and mid-packet valid gaps.
        force_ready = 1'b0;
        gaps        = 1'b1;
        for (int r = 0; r < 30; r++) begin
            clear_streams();
            any = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    any = 1'b1;
                    np  = $urandom_range(1, 3);
                    for (int p = 0; p < np; p++) begin
                        len = $urandom_range(1, 7);
                        for (int b = 0; b < len; b++) add_beat(k, 8'($urandom), b == len - 1);
                    end
                end
            end
            if (!any) add_beat($urandom_range(0, NREQ - 1), 8'($urandom), 1'b1);
            start_round();
            run_round("random", n);
        end

        // Reset in the middle of traffic, then requester 0 must win first.
        force_ready = 1'b1;
        gaps        = 1'b0;
        clear_streams();
        for (int k = 0; k < NREQ; k++)
            for (int b = 0; b < 3; b++) add_beat(k, 8'h80 + 8'(k * 4 + b), b == 2);
        start_round();
        repeat (4) begin
            tick_neg();
            tick_pos();
        end
        mon_en = 1'b0;
        rstn   = 1'b0;
        clear_streams();
        drive();
        tick_neg();
        tick_pos();
        tick_neg();
        chk_reset_outputs("midreset");
        tick_pos();
        rstn = 1'b1;
        expq.delete();
        mptr   = NREQ - 1;
        mon_en = 1'b1;
        clear_streams();
        add_beat(1, 8'h51, 1'b0);
        add_beat(1, 8'h52, 1'b1);
        add_beat(0, 8'h61, 1'b0);
        add_beat(0, 8'h62, 1'b1);
        start_round();
        run_round("after_reset", n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
